// File: rtl/scope_trace_renderer.sv
// Double-buffered multi-channel scope trace store and 2-cycle pixel renderer for the VGA scope.
// Optional graticule overlay is built when SCOPE_GRID_EN is defined.
module scope_trace_renderer #(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 640,
  parameter int SAMPLE_W = 10,
  parameter int VACTIVE  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        blank_n_in,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        blank_n_out
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = 11;
  localparam int NRAM  = 2 * NUM_CH;

  logic              front_sel;
  logic [IDX_W-1:0]  wr_idx;
  logic [CH_W-1:0]   wr_ch;
  logic              swap_pending;
  logic              overflow;
  logic [NUM_CH-1:0] ch_en;
  logic [9:0]        v_offset;

  logic             sample_wr, ctrl_wr, swap, full, wr_drop, wr_buf;
  logic [IDX_W-1:0] idx_eff, idx_next;
  logic [CH_W-1:0]  ch_eff, ch_next;

  assign sample_wr = chipselect && write && (address == 3'd0);
  assign ctrl_wr   = chipselect && write && (address == 3'd1);
  assign swap      = swap_pending && (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
  assign full      = (wr_idx == IDX_W'(DEPTH));

  // A write landing in the swap cycle targets the new back buffer, starting from index 0 / channel 0.
  assign wr_buf   = swap ? front_sel : ~front_sel;
  assign idx_eff  = swap ? {IDX_W{1'b0}} : wr_idx;
  assign ch_eff   = swap ? {CH_W{1'b0}} : wr_ch;
  assign wr_drop  = (idx_eff == IDX_W'(DEPTH));
  assign ch_next  = (ch_eff == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : ch_eff + CH_W'(1);
  assign idx_next = (ch_eff == CH_W'(NUM_CH - 1)) ? idx_eff + IDX_W'(1) : idx_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_sel    <= 1'b0;
      wr_idx       <= {IDX_W{1'b0}};
      wr_ch        <= {CH_W{1'b0}};
      swap_pending <= 1'b0;
      overflow     <= 1'b0;
      ch_en        <= {NUM_CH{1'b1}};
      v_offset     <= 10'd0;
    end else begin
      if (swap) begin
        front_sel    <= ~front_sel;
        swap_pending <= ctrl_wr && writedata[0];
      end else if (ctrl_wr && writedata[0]) begin
        swap_pending <= 1'b1;
      end
      if (sample_wr) begin
        if (wr_drop) begin
          overflow <= 1'b1;
        end else begin
          wr_idx <= idx_next;
          wr_ch  <= ch_next;
        end
      end else if (swap || (ctrl_wr && writedata[1])) begin
        wr_idx <= {IDX_W{1'b0}};
        wr_ch  <= {CH_W{1'b0}};
      end
      if (ctrl_wr && writedata[2]) begin
        overflow <= 1'b0;
      end
      if (chipselect && write && (address == 3'd2)) begin
        ch_en <= writedata[NUM_CH-1:0];
      end
      if (chipselect && write && (address == 3'd3)) begin
        v_offset <= writedata[9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 16'd0;
    end else if (chipselect && read) begin
      case (address)
        3'd1:    readdata <= {13'd0, overflow, full, swap_pending};
        3'd2:    readdata <= {{(16-NUM_CH){1'b0}}, ch_en};
        3'd3:    readdata <= {6'd0, v_offset};
        default: readdata <= 16'd0;
      endcase
    end else begin
      readdata <= 16'd0;
    end
  end

  // One RAM per (buffer, channel); RAM g holds buffer g/NUM_CH, channel g%NUM_CH.
  for (genvar g = 0; g < NRAM; g++) begin : g_ram
    localparam int BUF = g / NUM_CH;
    localparam int CH  = g % NUM_CH;
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] q;
    logic                we;
    assign we = sample_wr && !wr_drop && (wr_buf == 1'(BUF)) && (ch_eff == CH_W'(CH));
    always_ff @(posedge clk) begin
      if (we) begin
        mem[idx_eff[9:0]] <= writedata[SAMPLE_W-1:0];
      end
      q <= mem[hcount[10:1]];
    end
  end

  logic [9:0] col_d, vcount_d;
  logic       blank_d, front_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_d    <= 10'd0;
      vcount_d <= 10'd0;
      blank_d  <= 1'b0;
      front_d  <= 1'b0;
    end else begin
      col_d    <= hcount[10:1];
      vcount_d <= vcount;
      blank_d  <= blank_n_in;
      front_d  <= front_sel;
    end
  end

  logic              col_in_range;
  logic [NUM_CH-1:0] trace_hit;
  assign col_in_range = ({1'b0, col_d} < 11'(DEPTH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_hit
    logic [SAMPLE_W-1:0] sample;
    logic [9:0]          y;
    assign sample       = front_d ? g_ram[NUM_CH + c].q : g_ram[c].q;
    assign y            = 10'(sample) + v_offset;
    assign trace_hit[c] = ch_en[c] && col_in_range && (y == vcount_d);
  end

  function automatic logic [23:0] palette(input logic [1:0] ch);
    case (ch)
      2'd0:    palette = 24'h00FFFF;
      2'd1:    palette = 24'hFFFF00;
      2'd2:    palette = 24'hFF00FF;
      2'd3:    palette = 24'h00FF00;
      default: palette = 24'h000000;
    endcase
  endfunction

  logic [23:0] colour;

  // Walk channels high to low so the lowest hit index is the one left standing.
  always_comb begin
`ifdef SCOPE_GRID_EN
    colour = ((col_d[4:0] == 5'd0) || (vcount_d[4:0] == 5'd0)) ? 24'h404040 : 24'h000000;
`else
    colour = 24'h000000;
`endif
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      colour = trace_hit[c] ? palette(2'(c)) : colour;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
      blank_n_out <= 1'b0;
    end else begin
      {pix_r, pix_g, pix_b} <= blank_d ? colour : 24'h000000;
      blank_n_out           <= blank_d;
    end
  end

endmodule
